// File: rtl/ula_if.sv
// Operand/opcode/result bundle between the board inputs and the ALU.
interface ula_if;
  logic [3:0] switchs;
  logic [3:0] A;
  logic [3:0] B;
  logic [7:0] saida;

  // Board side drives the operation and operands and reads the result.
  modport master (
    output switchs,
    output A,
    output B,
    input  saida
  );

  // ALU side.
  modport slave (
    input  switchs,
    input  A,
    input  B,
    output saida
  );
endinterface

// File: rtl/ula.sv
// 4-bit ALU with 16 operations and a single registered 8-bit result.
module ula (
  input  logic   clk,
  input  logic   rst,
  ula_if.slave   bus
);

  logic [7:0] a8;
  logic [7:0] b8;
  logic [7:0] res;
  logic [7:0] saida_q;

  assign a8 = {4'b0, bus.A};
  assign b8 = {4'b0, bus.B};

  // Combinational result for the current opcode and operands.
  always_comb begin
    res = 8'h00;
    unique case (bus.switchs)
      4'b0000: res = a8 + b8;
      4'b0001: res = a8 - b8;
      4'b0010: res = a8 * b8;
      4'b0011: begin
        // Divide by zero reports the dividend as remainder and all-ones quotient.
        if (bus.B == 4'h0) res = {bus.A, 4'hF};
        else               res = {bus.A % bus.B, bus.A / bus.B};
      end
      4'b0100: res = {4'b0, bus.A & bus.B};
      4'b0101: res = {4'b0, bus.A | bus.B};
      4'b0110: res = {4'b0, bus.A ^ bus.B};
      4'b0111: res = {4'b0, ~(bus.A & bus.B)};
      4'b1000: res = {4'b0, ~(bus.A | bus.B)};
      4'b1001: res = {4'b0, ~(bus.A ^ bus.B)};
      4'b1010: res = {4'b0, ~bus.A};
      // Shift counts past the register width naturally produce zero.
      4'b1011: res = a8 << bus.B;
      4'b1100: res = a8 >> bus.B;
      4'b1101: res = {5'b0, bus.A < bus.B, bus.A > bus.B, bus.A == bus.B};
      4'b1110: res = a8 + 8'd1;
      4'b1111: res = a8 - 8'd1;
    endcase
  end

  // Result register; reset takes priority over any operation.
  always_ff @(posedge clk) begin
    if (rst) saida_q <= 8'h00;
    else     saida_q <= res;
  end

  assign bus.saida = saida_q;

endmodule

// File: tb/tb_ula.sv
// Self-checking bench for ula: directed plan vectors plus a random back-to-back run.
module tb_ula;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  logic [7:0] exp_q[$];

  ula_if bus();

  ula u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  // Reference model written with integer arithmetic.
  function automatic logic [7:0] model(input logic [3:0] op, input logic [3:0] a,
                                       input logic [3:0] b);
    int ai = int'(a);
    int bi = int'(b);
    int r = 0;
    case (op)
      4'd0:  r = ai + bi;
      4'd1:  r = (ai - bi) & 255;
      4'd2:  r = ai * bi;
      4'd3:  r = (bi == 0) ? ai * 16 + 15 : (ai % bi) * 16 + ai / bi;
      4'd4:  r = ai & bi;
      4'd5:  r = ai | bi;
      4'd6:  r = ai ^ bi;
      4'd7:  r = 15 - (ai & bi);
      4'd8:  r = 15 - (ai | bi);
      4'd9:  r = 15 - (ai ^ bi);
      4'd10: r = 15 - ai;
      4'd11: r = (ai * (1 << bi)) & 255;
      4'd12: r = ai / (1 << bi);
      4'd13: r = (ai == bi ? 1 : 0) + (ai > bi ? 2 : 0) + (ai < bi ? 4 : 0);
      4'd14: r = ai + 1;
      default: r = (ai - 1) & 255;
    endcase
    return r[7:0];
  endfunction

  // Drive one operation, queue its expected result, compare one edge later.
  task automatic step(input string tag, input logic r, input logic [3:0] op,
                      input logic [3:0] a, input logic [3:0] b, input logic [7:0] exp);
    logic [7:0] e;
    rst = r;
    bus.switchs = op;
    bus.A = a;
    bus.B = b;
    exp_q.push_back(r ? 8'h00 : exp);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check_eq({tag, "_noexp"}, bus.saida, 8'hxx);
    end else begin
      e = exp_q.pop_front();
      check_eq(tag, bus.saida, e);
    end
  endtask

  initial begin
    logic [3:0] op;
    logic [3:0] a;
    logic [3:0] b;
    bus.switchs = 4'h0;
    bus.A = 4'h0;
    bus.B = 4'h0;
    @(posedge clk);
    #1;

    step("rst0", 1'b1, 4'h0, 4'hF, 4'hF, 8'h00);
    step("rst1", 1'b1, 4'h0, 4'hF, 4'hF, 8'h00);
    step("rst_rel", 1'b0, 4'h0, 4'hF, 4'hF, 8'h1E);

    step("add0", 1'b0, 4'h0, 4'h0, 4'h0, 8'h00);
    step("add1", 1'b0, 4'h0, 4'h4, 4'h1, 8'h05);
    step("add2", 1'b0, 4'h0, 4'h8, 4'hF, 8'h17);
    step("add3", 1'b0, 4'h0, 4'hF, 4'hF, 8'h1E);

    step("sub", 1'b0, 4'h1, 4'h8, 4'h4, 8'h04);
    step("sub_wrap", 1'b0, 4'h1, 4'h0, 4'h1, 8'hFF);
    step("inc_wrap", 1'b0, 4'hE, 4'hF, 4'h0, 8'h10);
    step("dec_wrap", 1'b0, 4'hF, 4'h0, 4'h0, 8'hFF);

    step("mul", 1'b0, 4'h2, 4'hF, 4'hF, 8'hE1);
    step("div", 1'b0, 4'h3, 4'hD, 4'h4, 8'h13);
    step("div0", 1'b0, 4'h3, 4'h9, 4'h0, 8'h9F);

    step("and", 1'b0, 4'h4, 4'hA, 4'h6, 8'h02);
    step("or", 1'b0, 4'h5, 4'hA, 4'h6, 8'h0E);
    step("xor", 1'b0, 4'h6, 4'hA, 4'h6, 8'h0C);
    step("nand", 1'b0, 4'h7, 4'hA, 4'h6, 8'h0D);
    step("nor", 1'b0, 4'h8, 4'hA, 4'h6, 8'h01);
    step("xnor", 1'b0, 4'h9, 4'hA, 4'h6, 8'h03);
    step("not", 1'b0, 4'hA, 4'hA, 4'h6, 8'h05);
    step("shl", 1'b0, 4'hB, 4'hA, 4'h2, 8'h28);
    step("shr", 1'b0, 4'hC, 4'hA, 4'h1, 8'h05);
    step("cmp", 1'b0, 4'hD, 4'hA, 4'h6, 8'h02);
    step("cmp_eq", 1'b0, 4'hD, 4'h5, 4'h5, 8'h01);
    step("cmp_lt", 1'b0, 4'hD, 4'h3, 4'h9, 8'h04);
    step("shl_big", 1'b0, 4'hB, 4'hF, 4'h8, 8'h00);
    step("shl7", 1'b0, 4'hB, 4'h3, 4'h7, 8'h80);
    step("shr_big", 1'b0, 4'hC, 4'hF, 4'h4, 8'h00);

    // Back-to-back with a new opcode every cycle and a mid-stream reset.
    for (int i = 0; i < 48; i++) begin
      op = 4'(i);
      a = 4'($urandom_range(0, 15));
      b = 4'($urandom_range(0, 15));
      step($sformatf("b2b%0d", i), (i == 20 || i == 21), op, a, b, model(op, a, b));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
